// File: rtl/system1_cmd_pkg.sv
// Shared types and field positions for the command bridge between the output PIO,
// the processing engine and the status input PIO.
package system1_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  // cmd_word layout
  localparam int TOGGLE_BIT = 31;
  localparam int OPCODE_W   = 7;
  localparam int ARG_W      = 24;

  // status_word layout
  localparam int ACK_BIT  = 31;
  localparam int BUSY_BIT = 30;
  localparam int TMO_BIT  = 29;
  localparam int RESULT_W = 16;

  // Cycle counter width; covers the full legal TIMEOUT_CYCLES range
  localparam int CNT_W = 24;

endpackage

// File: rtl/system1_cmd_timeout.sv
// Command watchdog counter: cleared while the bridge is idle, counts while a
// command is outstanding, flags the cycle on which the count reaches LIMIT-1.
module system1_cmd_timeout
  import system1_cmd_pkg::*;
#(
  parameter int LIMIT = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic terminal_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign terminal_o = (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/system1_cmd_bridge.sv
// Toggle-handshake command bridge: PIO word -> valid/ready command -> engine done
// -> registered status word. Optional watchdog abort enabled by CMD_TIMEOUT_EN.
module system1_cmd_bridge
  import system1_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         cmd_word,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [OPCODE_W-1:0] cmd_opcode,
  output logic [ARG_W-1:0]    cmd_arg,
  input  logic                eng_done,
  input  logic [RESULT_W-1:0] eng_result,
  output logic [31:0]         status_word
);

  state_e              state_q, state_d;
  logic                ack_q, ack_d;
  logic                toggle_q, toggle_d;
  logic                busy_q, busy_d;
  logic                tmo_q, tmo_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [ARG_W-1:0]    arg_q, arg_d;
  logic                tmo_hit;

`ifdef CMD_TIMEOUT_EN
  system1_cmd_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (state_q == IDLE),
    .enable_i   (state_q != IDLE),
    .terminal_o (tmo_hit)
  );
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES > 1);
  assign tmo_hit    = 1'b0;
`endif

  // NOTE: every _d gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    toggle_d = toggle_q;
    busy_d   = busy_q;
    tmo_d    = tmo_q;
    result_d = result_q;
    opcode_d = opcode_q;
    arg_d    = arg_q;

    case (state_q)
      IDLE: begin
        if (cmd_word[TOGGLE_BIT] != ack_q) begin
          opcode_d = cmd_word[TOGGLE_BIT-1 -: OPCODE_W];
          arg_d    = cmd_word[ARG_W-1:0];
          toggle_d = cmd_word[TOGGLE_BIT];
          busy_d   = 1'b1;
          tmo_d    = 1'b0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          state_d = WAIT;
        end else if (tmo_hit) begin
          tmo_d    = 1'b1;
          result_d = '0;
          ack_d    = toggle_q;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      WAIT: begin
        // A done pulse on the terminal cycle still completes the command normally
        if (eng_done) begin
          result_d = eng_result;
          ack_d    = toggle_q;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else if (tmo_hit) begin
          tmo_d    = 1'b1;
          result_d = '0;
          ack_d    = toggle_q;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update from
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      toggle_q <= 1'b0;
      busy_q   <= 1'b0;
      tmo_q    <= 1'b0;
      result_q <= '0;
      opcode_q <= '0;
      arg_q    <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      toggle_q <= toggle_d;
      busy_q   <= busy_d;
      tmo_q    <= tmo_d;
      result_q <= result_d;
      opcode_q <= opcode_d;
      arg_q    <= arg_d;
    end
  end

  assign cmd_valid  = (state_q == ISSUE);
  assign cmd_opcode = opcode_q;
  assign cmd_arg    = arg_q;

  // Assembled purely from flops so the input PIO never sees a combinational path
  always_comb begin
    status_word                   = '0;
    status_word[ACK_BIT]          = ack_q;
    status_word[BUSY_BIT]         = busy_q;
    status_word[TMO_BIT]          = tmo_q;
    status_word[RESULT_W-1:0]     = result_q;
  end

endmodule

// File: tb/tb_system1_cmd_bridge.sv
// Directed self-checking bench for system1_cmd_bridge; the watchdog section runs
// only when CMD_TIMEOUT_EN is defined (TIMEOUT_CYCLES=16).
module tb_system1_cmd_bridge;

  logic        clk;
  logic        reset;
  logic [31:0] cmd_word;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_opcode;
  logic [23:0] cmd_arg;
  logic        eng_done;
  logic [15:0] eng_result;
  logic [31:0] status_word;

  int total;
  int bad;

  system1_cmd_bridge #(
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_word    (cmd_word),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_opcode  (cmd_opcode),
    .cmd_arg     (cmd_arg),
    .eng_done    (eng_done),
    .eng_result  (eng_result),
    .status_word (status_word)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then return at the following falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int vcount;
    int hold_err;
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    cmd_word   = 32'h0;
    cmd_ready  = 1'b0;
    eng_done   = 1'b0;
    eng_result = 16'h0;

    // Reset state and quiet idle period
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_status", status_word, 32'h0);
    check("rst_valid", {31'b0, cmd_valid}, 32'h0);
    check("rst_opcode", {25'b0, cmd_opcode}, 32'h0);
    check("rst_arg", {8'b0, cmd_arg}, 32'h0);
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cmd_valid) vcount++;
    end
    check("idle_no_valid", vcount, 0);

    // Basic command with ready tied high
    cmd_ready = 1'b1;
    cmd_word  = 32'h8512_3456;
    tick();
    check("issue_valid", {31'b0, cmd_valid}, 32'h1);
    check("issue_opcode", {25'b0, cmd_opcode}, 32'h05);
    check("issue_arg", {8'b0, cmd_arg}, 32'h123456);
    check("issue_busy", status_word, 32'h4000_0000);
    tick();
    check("valid_one_cycle", {31'b0, cmd_valid}, 32'h0);
    vcount = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cmd_valid) vcount++;
    end
    check("wait_no_valid", vcount, 0);
    eng_done   = 1'b1;
    eng_result = 16'hBEEF;
    tick();
    eng_done = 1'b0;
    check("done_status", status_word, 32'h8000_BEEF);

    // Stray done pulse while idle
    eng_done   = 1'b1;
    eng_result = 16'h1234;
    tick();
    eng_done = 1'b0;
    check("idle_done_ignored", status_word, 32'h8000_BEEF);

    // Back-pressure with a double toggle of cmd_word while busy
    cmd_ready = 1'b0;
    cmd_word  = 32'h0A00_00FF;
    tick();
    hold_err = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) cmd_word = 32'h8B00_0001;
      if (i == 6) cmd_word = 32'h0C00_0002;
      tick();
      if (!cmd_valid || cmd_opcode != 7'h0A || cmd_arg != 24'h0000FF) hold_err++;
    end
    check("stall_hold", hold_err, 0);
    check("stall_opcode", {25'b0, cmd_opcode}, 32'h0A);
    check("stall_arg", {8'b0, cmd_arg}, 32'h0000FF);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check("stall_accept", {31'b0, cmd_valid}, 32'h0);
    eng_done   = 1'b1;
    eng_result = 16'h5A5A;
    tick();
    eng_done = 1'b0;
    check("stall_done", status_word, 32'h0000_5A5A);
    vcount = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cmd_valid) vcount++;
    end
    check("no_second_cmd", vcount, 0);
    check("no_second_status", status_word, 32'h0000_5A5A);

    // Asynchronous reset while waiting on the engine
    cmd_word  = 32'h8100_0003;
    cmd_ready = 1'b1;
    tick();
    tick();
    cmd_ready = 1'b0;
    check("pre_rst_busy", status_word, 32'h4000_5A5A);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_status", status_word, 32'h0);
    check("async_rst_valid", {31'b0, cmd_valid}, 32'h0);
    check("async_rst_fields", {1'b0, cmd_opcode, cmd_arg}, 32'h0);
    cmd_word = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    vcount = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cmd_valid) vcount++;
    end
    check("post_rst_idle_valid", vcount, 0);
    check("post_rst_status", status_word, 32'h0);

`ifdef CMD_TIMEOUT_EN
    // Engine never answers: abort after 16 cycles outstanding
    cmd_word = 32'h8100_0007;
    tick();
    hold_err = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (status_word != 32'h4000_0000 || !cmd_valid) hold_err++;
    end
    check("tmo_pending", hold_err, 0);
    tick();
    check("tmo_status", status_word, 32'hA000_0000);
    check("tmo_valid", {31'b0, cmd_valid}, 32'h0);

    // Next command clears the flag; done on the terminal cycle wins
    cmd_word  = 32'h0200_0009;
    cmd_ready = 1'b1;
    tick();
    check("tmo_cleared", status_word, 32'hC000_0000);
    tick();
    cmd_ready = 1'b0;
    repeat (14) tick();
    check("tmo_edge_busy", status_word, 32'hC000_0000);
    eng_done   = 1'b1;
    eng_result = 16'h0C0D;
    tick();
    eng_done = 1'b0;
    check("tmo_done_wins", status_word, 32'h0000_0C0D);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
